op_loader: RTL and testbench

OP_LOADER -- requirements
Module: op_loader

---
 rtl/op_loader.sv | 131 +++++++++++++
 tb/tb_op_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_loader.sv
// Serial program loader: assembles 6-byte big-endian groups into instruction
// words and writes them to instruction memory until END_OP or memory is full.
module op_loader #(
   parameter int unsigned OP_W   = 44,
   parameter int unsigned ADDR_W = 12,
   parameter logic [7:0]  END_OP = 8'hFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [OP_W-1:0]   imem_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W = 3;
   localparam int unsigned ASM_W = 40;
   localparam int unsigned WL_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(5);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t              state_q, state_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [CNT_W-1:0]    cnt_q, cnt_nxt;
   logic [ASM_W-1:0]    asm_q, asm_nxt;
   logic                we_nxt, rdy_nxt, hold_nxt, done_nxt, ovf_nxt;
   logic [ADDR_W-1:0]   waddr_nxt;
   logic [OP_W-1:0]     wdata_nxt;
   logic [WL_W-1:0]     wl_nxt;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         asm_q        <= '0;
         in_ready     <= 1'b0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_data    <= '0;
         cpu_hold     <= 1'b0;
         done         <= 1'b0;
         overflow     <= 1'b0;
         words_loaded <= '0;
      end else begin
         state_q      <= state_nxt;
         addr_q       <= addr_nxt;
         cnt_q        <= cnt_nxt;
         asm_q        <= asm_nxt;
         in_ready     <= rdy_nxt;
         imem_we      <= we_nxt;
         imem_addr    <= waddr_nxt;
         imem_data    <= wdata_nxt;
         cpu_hold     <= hold_nxt;
         done         <= done_nxt;
         overflow     <= ovf_nxt;
         words_loaded <= wl_nxt;
      end
   end

   // Next-state and next-output logic; the write strobe is launched on the
   // 6th byte so it is visible during the WRITE cycle itself
   always_comb begin
      state_nxt = state_q;
      addr_nxt  = addr_q;
      cnt_nxt   = cnt_q;
      asm_nxt   = asm_q;
      we_nxt    = 1'b0;
      waddr_nxt = imem_addr;
      wdata_nxt = imem_data;
      done_nxt  = done;
      ovf_nxt   = overflow;
      wl_nxt    = words_loaded;

      if (start) begin
         state_nxt = LOAD;
         addr_nxt  = '0;
         cnt_nxt   = '0;
         asm_nxt   = '0;
         done_nxt  = 1'b0;
         ovf_nxt   = 1'b0;
         wl_nxt    = '0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid) begin
                  asm_nxt = {asm_q[ASM_W-9:0], in_data};
                  if (cnt_q == LAST_BYTE) begin
                     // Top nibble of byte 0 falls off in the truncation
                     cnt_nxt   = '0;
                     we_nxt    = 1'b1;
                     waddr_nxt = addr_q;
                     wdata_nxt = OP_W'({asm_q, in_data});
                     wl_nxt    = words_loaded + WL_W'(1);
                     state_nxt = WRITE;
                  end else begin
                     cnt_nxt = cnt_q + CNT_W'(1);
                  end
               end
            end
            WRITE: begin
               if (imem_data[OP_W-1 -: 8] == END_OP) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
               end else if (addr_q == {ADDR_W{1'b1}}) begin
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
                  ovf_nxt   = 1'b1;
               end else begin
                  addr_nxt  = addr_q + ADDR_W'(1);
                  state_nxt = LOAD;
               end
            end
            default: ;
         endcase
      end

      rdy_nxt  = (state_nxt == LOAD);
      hold_nxt = (state_nxt == LOAD) || (state_nxt == WRITE);
   end

endmodule

// File: tb/tb_op_loader.sv
// Directed bench for op_loader: per-cycle vector table plus multi-cycle sequences.
module tb_op_loader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [11:0] imem_addr;
   logic [43:0] imem_data;
   logic        cpu_hold;
   logic        done;
   logic        overflow;
   logic [12:0] words_loaded;

   op_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_data(imem_data), .cpu_hold(cpu_hold),
      .done(done), .overflow(overflow), .words_loaded(words_loaded)
   );

   typedef struct {
      logic        st;
      logic        vld;
      logic [7:0]  dat;
      logic        rdy;
      logic        we;
      logic [11:0] addr;
      logic [43:0] data;
      logic        hold;
      logic        dn;
      logic        ovf;
      logic [12:0] wl;
   } vec_t;

   localparam logic [43:0] D1 = 44'h001_2345_6789;
   localparam logic [43:0] D2 = 44'hFF0_0000_0000;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [55:0] wq[$];
   int          wcyc[$];
   logic [7:0]  prog[12] = '{8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                             8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
   vec_t        tbl[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write log taken mid-cycle
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wq.push_back({imem_addr, imem_data});
         wcyc.push_back(cyc);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_rdy"},  64'(in_ready), 64'd0);
      chk({p, "_we"},   64'(imem_we), 64'd0);
      chk({p, "_addr"}, 64'(imem_addr), 64'd0);
      chk({p, "_data"}, 64'(imem_data), 64'd0);
      chk({p, "_hold"}, 64'(cpu_hold), 64'd0);
      chk({p, "_done"}, 64'(done), 64'd0);
      chk({p, "_ovf"},  64'(overflow), 64'd0);
      chk({p, "_wl"},   64'(words_loaded), 64'd0);
   endtask

   // Present a byte until an edge with in_ready high accepts it
   task automatic send_byte(input logic [7:0] b, output int acc);
      logic r;
      int   budget;
      r = 1'b0;
      budget = 0;
      in_data = b;
      in_valid = 1'b1;
      while (!r && budget < 50) begin
         @(negedge clk);
         r = in_ready;
         tick();
         budget++;
      end
      in_valid = 1'b0;
      acc = cyc;
      if (!r) chk("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   function automatic vec_t mk(logic st, logic vld, logic [7:0] dat, logic rdy, logic we,
                               logic [11:0] addr, logic [43:0] data, logic hold,
                               logic dn, logic ovf, logic [12:0] wl);
      vec_t v;
      v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we; v.addr = addr;
      v.data = data; v.hold = hold; v.dn = dn; v.ovf = ovf; v.wl = wl;
      return v;
   endfunction

   initial begin
      int acc, a5, a11, errs;
      logic [15:0] w16;

      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #3 rst_n = 1'b0;
      #1 chk_zero("rst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      in_valid = 1'b1; in_data = 8'h77;
      repeat (3) tick();
      in_valid = 1'b0;
      chk_zero("idle");

      // Per-cycle table: two-word program ending in END_OP
      tbl[0] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 12'd0, 44'd0, 1'b1, 1'b0, 1'b0, 13'd0);
      for (int i = 1; i <= 5; i++)
         tbl[i] = mk(1'b0, 1'b1, prog[i-1], 1'b1, 1'b0, 12'd0, 44'd0, 1'b1, 1'b0, 1'b0, 13'd0);
      tbl[6] = mk(1'b0, 1'b1, prog[5], 1'b0, 1'b1, 12'd0, D1, 1'b1, 1'b0, 1'b0, 13'd1);
      tbl[7] = mk(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 12'd0, D1, 1'b1, 1'b0, 1'b0, 13'd1);
      for (int i = 8; i <= 12; i++)
         tbl[i] = mk(1'b0, 1'b1, prog[i-2], 1'b1, 1'b0, 12'd0, D1, 1'b1, 1'b0, 1'b0, 13'd1);
      tbl[13] = mk(1'b0, 1'b1, prog[11], 1'b0, 1'b1, 12'd1, D2, 1'b1, 1'b0, 1'b0, 13'd2);
      tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'd1, D2, 1'b0, 1'b1, 1'b0, 13'd2);
      tbl[15] = mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 12'd1, D2, 1'b0, 1'b1, 1'b0, 13'd2);

      for (int i = 0; i < 16; i++) begin
         start = tbl[i].st; in_valid = tbl[i].vld; in_data = tbl[i].dat;
         tick();
         start = 1'b0; in_valid = 1'b0;
         chk($sformatf("v%0d_rdy", i),  64'(in_ready), 64'(tbl[i].rdy));
         chk($sformatf("v%0d_we", i),   64'(imem_we), 64'(tbl[i].we));
         chk($sformatf("v%0d_addr", i), 64'(imem_addr), 64'(tbl[i].addr));
         chk($sformatf("v%0d_data", i), 64'(imem_data), 64'(tbl[i].data));
         chk($sformatf("v%0d_hold", i), 64'(cpu_hold), 64'(tbl[i].hold));
         chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].dn));
         chk($sformatf("v%0d_ovf", i),  64'(overflow), 64'(tbl[i].ovf));
         chk($sformatf("v%0d_wl", i),   64'(words_loaded), 64'(tbl[i].wl));
      end

      // Throttled input, one valid cycle in three
      wq.delete(); wcyc.delete(); a5 = 0; a11 = 0;
      pulse_start();
      for (int i = 0; i < 12; i++) begin
         repeat (2) tick();
         send_byte(prog[i], acc);
         if (i == 5) a5 = acc;
         if (i == 11) a11 = acc;
      end
      repeat (3) tick();
      chk("thr_nwrites", 64'(wq.size()), 64'd2);
      if (wq.size() >= 2) begin
         chk("thr_w0", 64'(wq[0]), 64'({12'd0, D1}));
         chk("thr_w1", 64'(wq[1]), 64'({12'd1, D2}));
         chk("thr_lat0", 64'(wcyc[0]), 64'(a5));
         chk("thr_lat1", 64'(wcyc[1]), 64'(a11));
      end
      chk("thr_done", 64'(done), 64'd1);
      chk("thr_wl", 64'(words_loaded), 64'd2);

      // Restart after a partial word
      wq.delete();
      pulse_start();
      send_byte(8'hAA, acc); send_byte(8'hBB, acc); send_byte(8'hCC, acc);
      pulse_start();
      send_byte(8'h00, acc); send_byte(8'h0A, acc); send_byte(8'hBC, acc);
      send_byte(8'hDE, acc); send_byte(8'hF0, acc); send_byte(8'h12, acc);
      tick();
      chk("part_nwrites", 64'(wq.size()), 64'd1);
      if (wq.size() >= 1) chk("part_w0", 64'(wq[0]), 64'({12'd0, 44'h00A_BCDE_F012}));
      chk("part_wl", 64'(words_loaded), 64'd1);

      // Start coinciding with the WRITE cycle
      wq.delete();
      pulse_start();
      for (int i = 0; i < 6; i++) send_byte(prog[i], acc);
      chk("sw_we", 64'(imem_we), 64'd1);
      pulse_start();
      chk("sw_nwrites", 64'(wq.size()), 64'd1);
      chk("sw_rdy", 64'(in_ready), 64'd1);
      chk("sw_hold", 64'(cpu_hold), 64'd1);
      chk("sw_wl", 64'(words_loaded), 64'd0);
      chk("sw_done", 64'(done), 64'd0);
      for (int i = 6; i < 12; i++) send_byte(prog[i], acc);
      repeat (2) tick();
      chk("sw_nwrites2", 64'(wq.size()), 64'd2);
      if (wq.size() >= 2) chk("sw_w1", 64'(wq[1]), 64'({12'd0, D2}));
      chk("sw_done2", 64'(done), 64'd1);
      chk("sw_wl2", 64'(words_loaded), 64'd1);

      // Asynchronous reset mid-word
      wq.delete();
      pulse_start();
      send_byte(8'h11, acc); send_byte(8'h22, acc); send_byte(8'h33, acc);
      #2 rst_n = 1'b0;
      #1 chk_zero("arst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      in_valid = 1'b1; in_data = 8'h5A;
      repeat (10) tick();
      in_valid = 1'b0;
      chk_zero("arst_idle");
      chk("arst_nwrites", 64'(wq.size()), 64'd0);
      pulse_start();
      for (int i = 6; i < 12; i++) send_byte(prog[i], acc);
      repeat (2) tick();
      chk("arst_nwrites2", 64'(wq.size()), 64'd1);
      if (wq.size() >= 1) chk("arst_w0", 64'(wq[0]), 64'({12'd0, D2}));

      // Fill all 4096 words without END_OP
      wq.delete();
      pulse_start();
      for (int w = 0; w < 4096; w++) begin
         w16 = 16'(w);
         send_byte(8'h00, acc); send_byte(8'h00, acc); send_byte(8'h00, acc);
         send_byte(8'h12, acc); send_byte(w16[15:8], acc); send_byte(w16[7:0], acc);
      end
      repeat (3) tick();
      chk("ovf_nwrites", 64'(wq.size()), 64'd4096);
      errs = 0;
      for (int i = 0; i < wq.size(); i++)
         if (wq[i] !== {12'(i), 28'h0000012, 16'(i)}) errs++;
      chk("ovf_seq_errs", 64'(errs), 64'd0);
      if (wq.size() >= 1) chk("ovf_last_addr", 64'(wq[wq.size()-1][55:44]), 64'hFFF);
      chk("ovf_done", 64'(done), 64'd1);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_wl", 64'(words_loaded), 64'd4096);
      chk("ovf_hold", 64'(cpu_hold), 64'd0);
      chk("ovf_rdy", 64'(in_ready), 64'd0);
      in_valid = 1'b1; in_data = 8'h00;
      repeat (10) tick();
      in_valid = 1'b0;
      chk("ovf_no_wrap", 64'(wq.size()), 64'd4096);
      pulse_start();
      chk("ovf_clr_done", 64'(done), 64'd0);
      chk("ovf_clr_flag", 64'(overflow), 64'd0);
      chk("ovf_clr_wl", 64'(words_loaded), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
